sobel_ctrl: RTL and testbench

SOBEL_CTRL -- requirements
Module: sobel_ctrl

---
 rtl/sobel_pkg.sv | 24 ++
 rtl/sobel_ctrl_dly.sv | 26 ++
 rtl/sobel_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_sobel_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel frame controller.
package sobel_pkg;

   localparam int unsigned DEF_ADDR_W    = 8;
   localparam int unsigned DEF_SOBEL_LAT = 3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      TOP   = 3'd1,
      SCAN  = 3'd2,
      FLUSH = 3'd3,
      BOT   = 3'd4,
      DONE  = 3'd5
   } state_t;

   // Write-slot tag travelling alongside the Sobel datapath.
   typedef struct packed {
      logic                  valid;
      logic [DEF_ADDR_W-1:0] row;
      logic [DEF_ADDR_W-1:0] col;
      logic                  zero;
   } tag_t;

endpackage

// File: rtl/sobel_ctrl_dly.sv
// Tag delay line matching the Sobel pipeline latency; cleared by async reset.
module sobel_ctrl_dly
   import sobel_pkg::*;
#(
   parameter int unsigned SOBEL_LAT = DEF_SOBEL_LAT
) (
   input  logic clk,
   input  logic reset,
   input  tag_t tag_in,
   output tag_t tag_out
);

   tag_t stage [SOBEL_LAT];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < SOBEL_LAT; i++) stage[i] <= '0;
      end else begin
         stage[0] <= tag_in;
         for (int unsigned i = 1; i < SOBEL_LAT; i++) stage[i] <= stage[i-1];
      end
   end

   assign tag_out = stage[SOBEL_LAT-1];

endmodule

// File: rtl/sobel_ctrl.sv
// Sobel frame controller: read scan, tag pipeline and write addressing.
// Optional zero-border writes enabled by macro SOBEL_CTRL_BORDER_EN.
module sobel_ctrl
   import sobel_pkg::*;
#(
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter int unsigned SOBEL_LAT = DEF_SOBEL_LAT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] img_w,
   input  logic [ADDR_W-1:0] img_h,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_row,
   output logic [ADDR_W-1:0] rd_col,
   output logic              sobel_en,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_row,
   output logic [ADDR_W-1:0] wr_col,
   output logic              wr_zero,
   output logic              busy,
   output logic              done
);

   localparam int unsigned CNT_W = $clog2(SOBEL_LAT + 1);

   state_t            state;
   logic [ADDR_W-1:0] w_q, h_q;
   logic [CNT_W-1:0]  flush_cnt;
   tag_t              tag_in, tag_q;

`ifdef SOBEL_CTRL_BORDER_EN
   logic              bwr_en;
   logic [ADDR_W-1:0] bwr_row, bwr_col;
`endif

   // Write slot for the read issued this cycle; emerges SOBEL_LAT cycles later.
   always_comb begin
      tag_in = '0;
      if (rd_en && rd_col >= ADDR_W'(2)) begin
         tag_in.valid = 1'b1;
         tag_in.row   = rd_row + 1'b1;
         tag_in.col   = rd_col - 1'b1;
      end
`ifdef SOBEL_CTRL_BORDER_EN
      else if (rd_en && rd_col == '0 && rd_row != '0) begin
         tag_in = '{valid: 1'b1, row: rd_row, col: w_q - 1'b1, zero: 1'b1};
      end else if (rd_en && rd_col == ADDR_W'(1)) begin
         tag_in = '{valid: 1'b1, row: rd_row + 1'b1, col: '0, zero: 1'b1};
      end else if (state == FLUSH && flush_cnt == '0) begin
         tag_in = '{valid: 1'b1, row: h_q - 2'd2, col: w_q - 1'b1, zero: 1'b1};
      end
`endif
   end

   sobel_ctrl_dly #(.SOBEL_LAT(SOBEL_LAT)) u_dly (
      .clk     (clk),
      .reset   (reset),
      .tag_in  (tag_in),
      .tag_out (tag_q)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         w_q       <= '0;
         h_q       <= '0;
         flush_cnt <= '0;
         rd_en     <= 1'b0;
         rd_row    <= '0;
         rd_col    <= '0;
         sobel_en  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef SOBEL_CTRL_BORDER_EN
         bwr_en    <= 1'b0;
         bwr_row   <= '0;
         bwr_col   <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               w_q  <= img_w;
               h_q  <= img_h;
               busy <= 1'b1;
               if (img_w < ADDR_W'(3) || img_h < ADDR_W'(3)) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
`ifdef SOBEL_CTRL_BORDER_EN
                  state   <= TOP;
                  bwr_en  <= 1'b1;
                  bwr_row <= '0;
                  bwr_col <= '0;
`else
                  state    <= SCAN;
                  rd_en    <= 1'b1;
                  sobel_en <= 1'b1;
                  rd_row   <= '0;
                  rd_col   <= '0;
`endif
               end
            end
`ifdef SOBEL_CTRL_BORDER_EN
            TOP: begin
               if (bwr_col == w_q - 1'b1) begin
                  bwr_en   <= 1'b0;
                  bwr_col  <= '0;
                  state    <= SCAN;
                  rd_en    <= 1'b1;
                  sobel_en <= 1'b1;
               end else begin
                  bwr_col <= bwr_col + 1'b1;
               end
            end
            // First BOT cycle is left free for the flush slot draining out of the delay line.
            BOT: begin
               if (!bwr_en) begin
                  bwr_en  <= 1'b1;
                  bwr_row <= h_q - 1'b1;
                  bwr_col <= '0;
               end else if (bwr_col == w_q - 1'b1) begin
                  bwr_en  <= 1'b0;
                  bwr_row <= '0;
                  bwr_col <= '0;
                  state   <= DONE;
                  done    <= 1'b1;
               end else begin
                  bwr_col <= bwr_col + 1'b1;
               end
            end
`endif
            SCAN: begin
               if (rd_col == w_q - 1'b1) begin
                  rd_col <= '0;
                  if (rd_row == h_q - 2'd3) begin
                     state     <= FLUSH;
                     rd_en     <= 1'b0;
                     rd_row    <= '0;
                     flush_cnt <= '0;
                  end else begin
                     rd_row <= rd_row + 1'b1;
                  end
               end else begin
                  rd_col <= rd_col + 1'b1;
               end
            end
            FLUSH: begin
               if (flush_cnt == CNT_W'(SOBEL_LAT - 1)) begin
                  sobel_en <= 1'b0;
`ifdef SOBEL_CTRL_BORDER_EN
                  state    <= BOT;
`else
                  state    <= DONE;
                  done     <= 1'b1;
`endif
               end else begin
                  flush_cnt <= flush_cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SOBEL_CTRL_BORDER_EN
   assign wr_en   = tag_q.valid | bwr_en;
   assign wr_row  = tag_q.row | bwr_row;
   assign wr_col  = tag_q.col | bwr_col;
   assign wr_zero = tag_q.zero | bwr_en;
`else
   assign wr_en   = tag_q.valid;
   assign wr_row  = tag_q.row;
   assign wr_col  = tag_q.col;
   assign wr_zero = tag_q.zero;
`endif

endmodule

// File: tb/tb_sobel_ctrl.sv
// Directed bench for sobel_ctrl: frame read/write traffic, timing, restart and reset abort.
module tb_sobel_ctrl;

   localparam int LAT = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [7:0] img_w = '0, img_h = '0;
   logic       rd_en, sobel_en, wr_en, wr_zero, busy, done;
   logic [7:0] rd_row, rd_col, wr_row, wr_col;

   int passed = 0, total = 0;
   int cyc = 0;
   int cur_w, cur_h, exp_r, exp_c;
   int rd_cnt, wr_cnt, zero_cnt, done_cnt, done_cyc, sob_cnt;
   int ord_err, lat_err, zero_err;
   int wr_map [16][16];
   bit hist_v [64];
   int hist_r [64], hist_c [64];

   sobel_ctrl #(.ADDR_W(8), .SOBEL_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .start(start), .img_w(img_w), .img_h(img_h),
      .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .sobel_en(sobel_en),
      .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_zero(wr_zero),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic bit is_edge(input int r, input int c);
      return r == 0 || c == 0 || r == cur_h - 1 || c == cur_w - 1;
   endfunction

   // Bus monitor, sampled on the falling edge.
   always @(negedge clk) begin
      hist_v[cyc & 63] = rd_en;
      hist_r[cyc & 63] = rd_row;
      hist_c[cyc & 63] = rd_col;
      if (sobel_en) sob_cnt++;
      if (rd_en) begin
         rd_cnt++;
         if (rd_row != exp_r || rd_col != exp_c) ord_err++;
         exp_c++;
         if (exp_c == cur_w) begin exp_c = 0; exp_r++; end
      end
      if (wr_en) begin
         wr_cnt++;
         if (wr_zero) zero_cnt++;
         if (wr_row < 16 && wr_col < 16) wr_map[wr_row][wr_col]++;
`ifdef SOBEL_CTRL_BORDER_EN
         if (wr_zero != is_edge(wr_row, wr_col)) zero_err++;
`else
         if (wr_zero) zero_err++;
`endif
         if (!wr_zero) begin
            if (!hist_v[(cyc - LAT) & 63] ||
                hist_r[(cyc - LAT) & 63] + 1 != wr_row ||
                hist_c[(cyc - LAT) & 63] - 1 != wr_col) lat_err++;
         end
      end
      if (done) begin
         if (done_cnt == 0) done_cyc = cyc;
         done_cnt++;
      end
   end

   task automatic run_frame(input string name, input int w, input int h, input bit poke);
      int s, n, bad, exp_rd, exp_wr, exp_zero, exp_dt, exp_map;
      cur_w = w; cur_h = h; exp_r = 0; exp_c = 0;
      rd_cnt = 0; wr_cnt = 0; zero_cnt = 0; done_cnt = 0; sob_cnt = 0;
      ord_err = 0; lat_err = 0; zero_err = 0;
      for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) wr_map[r][c] = 0;
      @(posedge clk); #1;
      img_w = 8'(w); img_h = 8'(h); start = 1'b1; s = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      if (poke) begin
         repeat (4) @(posedge clk);
         #1 img_w = 8'd9; img_h = 8'd9; start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
      end
      n = 0;
      while (done_cnt == 0 && n < 3000) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);

      if (w < 3 || h < 3) begin
         exp_rd = 0; exp_wr = 0; exp_zero = 0; exp_dt = 1;
      end else begin
         exp_rd = w * (h - 2);
`ifdef SOBEL_CTRL_BORDER_EN
         exp_wr = w * h; exp_zero = 2 * w + 2 * (h - 2);
         exp_dt = 1 + w + w * (h - 2) + LAT + w + 1;
`else
         exp_wr = (w - 2) * (h - 2); exp_zero = 0;
         exp_dt = 1 + w * (h - 2) + LAT;
`endif
      end
      bad = 0;
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) begin
            exp_map = 0;
            if (w >= 3 && h >= 3 && r < h && c < w) begin
`ifdef SOBEL_CTRL_BORDER_EN
               exp_map = 1;
`else
               exp_map = is_edge(r, c) ? 0 : 1;
`endif
            end
            if (wr_map[r][c] != exp_map) bad++;
         end
      check($sformatf("%s.done_cnt", name), done_cnt, 1);
      check($sformatf("%s.reads", name), rd_cnt, exp_rd);
      check($sformatf("%s.writes", name), wr_cnt, exp_wr);
      check($sformatf("%s.zero_writes", name), zero_cnt, exp_zero);
      check($sformatf("%s.done_delay", name), done_cyc - s, exp_dt);
      check($sformatf("%s.sobel_en_cycles", name), sob_cnt, exp_rd == 0 ? 0 : exp_rd + LAT);
      check($sformatf("%s.map_bad_cells", name), bad, 0);
      check($sformatf("%s.read_order_err", name), ord_err, 0);
      check($sformatf("%s.write_latency_err", name), lat_err, 0);
      check($sformatf("%s.zero_flag_err", name), zero_err, 0);
      check($sformatf("%s.busy_after", name), int'(busy), 0);
   endtask

   initial begin
      cur_w = 0; cur_h = 0; exp_r = 0; exp_c = 0;
      rd_cnt = 0; wr_cnt = 0; zero_cnt = 0; done_cnt = 0; done_cyc = 0; sob_cnt = 0;
      ord_err = 0; lat_err = 0; zero_err = 0;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            int'({rd_en, sobel_en, wr_en, wr_zero, busy, done, rd_row, rd_col, wr_row, wr_col}), 0);
      @(posedge clk); #1 reset = 1'b1;

      run_frame("f4x4", 4, 4, 1'b0);
      run_frame("f2x5", 2, 5, 1'b0);
      run_frame("f5x6_restart", 5, 6, 1'b1);

      // Abort an 8x8 frame part way through the scan.
      cur_w = 8; cur_h = 8; exp_r = 0; exp_c = 0;
      @(posedge clk); #1 img_w = 8'd8; img_h = 8'd8; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (12) @(posedge clk);
      #1 check("pre_abort_busy", int'(busy), 1);
      check("pre_abort_rd_en", int'(rd_en), 1);
      reset = 1'b0;
      #1 check("abort_outputs",
               int'({rd_en, sobel_en, wr_en, wr_zero, busy, done, rd_row, rd_col, wr_row, wr_col}), 0);
      done_cnt = 0;
      repeat (3) @(negedge clk);
      check("abort_no_done", done_cnt, 0);
      @(posedge clk); #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      check("abort_stays_idle", int'({busy, rd_en, wr_en}), 0);

      run_frame("f8x8", 8, 8, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
